// File: rtl/sh7604_bsc_pkg.sv
// rtl/sh7604_bsc_pkg.sv - SH7604 bus state controller types and WCR constants
package sh7604_bsc_pkg;

   localparam logic [31:0] WCR_ADDR  = 32'hFFFFFFE8;
   localparam logic [15:0] WCR_INIT  = 16'hAAFF;
   localparam logic [15:0] WCR_WMASK = 16'hFFFF;
   localparam logic [15:0] WCR_RMASK = 16'hFFFF;

   typedef struct packed {
      logic [7:0] RSV;
      logic [1:0] W3;
      logic [1:0] W2;
      logic [1:0] W1;
      logic [1:0] W0;
   } WCR_t;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      TW,
      T2,
      IDLE_CYC
   } BSCState_t;

endpackage

// File: rtl/sh7604_bsc.sv
// rtl/sh7604_bsc.sv - SH7604 bus state controller (T1/TW/T2 cycles, WCR wait states, bursts)
// Optional idle cycle after T2: SH7604_BSC_IDLE_CYCLE_EN
module sh7604_bsc #(
   parameter logic [31:0] WCR_ADDR = sh7604_bsc_pkg::WCR_ADDR,
   parameter logic [15:0] WCR_INIT = sh7604_bsc_pkg::WCR_INIT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic [31:0] DBUS_A,
   input  logic [31:0] DBUS_DI,
   output logic [31:0] DBUS_DO,
   input  logic [3:0]  DBUS_BA,
   input  logic        DBUS_WE,
   input  logic        DBUS_REQ,
   input  logic        DBUS_BURST,
   input  logic        DBUS_LOCK,
   output logic        DBUS_WAIT,
   output logic        BSC_ACK,
   input  logic [31:0] IBUS_A,
   input  logic [31:0] IBUS_DI,
   output logic [31:0] IBUS_DO,
   input  logic        IBUS_WE,
   input  logic        IBUS_REQ,
   output logic        IBUS_ACT,
   output logic [26:0] A,
   output logic [31:0] DO,
   input  logic [31:0] DI,
   output logic [3:0]  CS_N,
   output logic        RD_N,
   output logic [3:0]  WE_N,
   input  logic        WAIT_N
);
   import sh7604_bsc_pkg::*;

   function automatic logic [1:0] f_area_wait(input WCR_t wcr, input logic [1:0] area);
      logic [1:0] w;
      case (area)
         2'd0:    w = wcr.W0;
         2'd1:    w = wcr.W1;
         2'd2:    w = wcr.W2;
         default: w = wcr.W3;
      endcase
      return w;
   endfunction

   BSCState_t   r_state, w_state_nxt, w_t2_exit;
   WCR_t        r_wcr;
   logic [26:0] r_addr;
   logic [31:0] r_wdata, r_dbus_do, r_ibus_do;
   logic [3:0]  r_ba;
   logic        r_we, r_burst;
   logic [1:0]  r_beat, r_w, r_wcnt;
   logic [1:0]  w_area, w_wait_t1;
   logic        w_load, w_capture, w_beat_inc, w_busy, w_wcr_wr, w_rd_n;
   logic [3:0]  w_cs_n, w_we_n;
   logic        w_unused;

   assign w_area    = r_addr[26:25];
   assign w_wait_t1 = f_area_wait(r_wcr, w_area);
   assign IBUS_ACT  = (IBUS_A == WCR_ADDR);
   assign w_wcr_wr  = IBUS_REQ & IBUS_WE & IBUS_ACT;
   assign w_unused  = ^{DBUS_A[31:27], IBUS_DI[31:16], DBUS_LOCK};

`ifdef SH7604_BSC_IDLE_CYCLE_EN
   assign w_t2_exit = DBUS_LOCK ? IDLE : IDLE_CYC;
`else
   assign w_t2_exit = IDLE;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else if (CE_R) r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_beat_inc  = 1'b0;
      w_busy      = 1'b0;
      w_cs_n      = 4'hF;
      w_rd_n      = 1'b1;
      w_we_n      = 4'hF;
      case (r_state)
         IDLE: if (DBUS_REQ) begin
            w_state_nxt = T1;
            w_load      = 1'b1;
         end
         T1: begin
            w_busy = 1'b1;
            if (w_wait_t1 == 2'd0) begin
               w_state_nxt = T2;
               w_capture   = 1'b1;
            end else begin
               w_state_nxt = TW;
            end
         end
         TW: begin
            w_busy = 1'b1;
            if (r_wcnt == 2'd0 && WAIT_N) begin
               w_state_nxt = T2;
               w_capture   = 1'b1;
            end
         end
         T2: begin
            w_busy = 1'b1;
            // Later burst beats reuse the W latched in T1 and skip T1.
            if (r_burst && r_beat != 2'd3) begin
               w_beat_inc = 1'b1;
               if (r_w == 2'd0) begin
                  w_state_nxt = T2;
                  w_capture   = 1'b1;
               end else begin
                  w_state_nxt = TW;
               end
            end else begin
               w_state_nxt = w_t2_exit;
            end
         end
         IDLE_CYC: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
      if (w_busy) begin
         w_cs_n = ~(4'b0001 << w_area);
         w_rd_n = r_we;
         if (r_we && r_state != T1) w_we_n = ~r_ba;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ba      <= '0;
         r_we      <= 1'b0;
         r_burst   <= 1'b0;
         r_beat    <= '0;
         r_w       <= '0;
         r_wcnt    <= '0;
         r_dbus_do <= '0;
         r_ibus_do <= '0;
         r_wcr     <= WCR_t'(WCR_INIT);
      end else begin
         if (CE_R) begin
            if (w_load) begin
               r_addr  <= DBUS_A[26:0];
               r_wdata <= DBUS_DI;
               r_ba    <= DBUS_BA;
               r_we    <= DBUS_WE;
               r_burst <= DBUS_BURST;
            end
            if (r_state == T1) begin
               r_w    <= w_wait_t1;
               r_wcnt <= w_wait_t1 - 2'd1;
            end else if (r_state == TW && r_wcnt != 2'd0) begin
               r_wcnt <= r_wcnt - 2'd1;
            end else if (w_beat_inc) begin
               r_beat <= r_beat + 2'd1;
               r_addr <= r_addr + 27'd4;
               r_wcnt <= r_w - 2'd1;
            end else if (r_state == T2) begin
               r_beat <= 2'd0;
            end
            if (w_capture) r_dbus_do <= DI;
            if (w_wcr_wr) r_wcr <= (IBUS_DI[15:0] & WCR_WMASK) | (r_wcr & ~WCR_WMASK);
         end
         if (CE_F) r_ibus_do <= IBUS_ACT ? {16'h0, r_wcr & WCR_RMASK} : 32'h0;
      end
   end

   assign DBUS_DO   = r_dbus_do;
   assign IBUS_DO   = r_ibus_do;
   assign A         = r_addr;
   assign DO        = r_wdata;
   assign CS_N      = w_cs_n;
   assign RD_N      = w_rd_n;
   assign WE_N      = w_we_n;
   assign BSC_ACK   = w_busy;
   assign DBUS_WAIT = DBUS_REQ & (r_state != T2);

endmodule

// File: tb/tb_sh7604_bsc.sv
// tb/tb_sh7604_bsc.sv - directed vector bench for sh7604_bsc
module tb_sh7604_bsc;

   localparam logic [31:0] WCR_A = 32'hFFFFFFE8;
`ifdef SH7604_BSC_IDLE_CYCLE_EN
   localparam int IDLE_GAP = 2;
`else
   localparam int IDLE_GAP = 1;
`endif

   logic        CLK = 1'b0;
   logic        RST, CE_R, CE_F;
   logic [31:0] DBUS_A, DBUS_DI, DBUS_DO;
   logic [3:0]  DBUS_BA;
   logic        DBUS_WE, DBUS_REQ, DBUS_BURST, DBUS_LOCK, DBUS_WAIT, BSC_ACK;
   logic [31:0] IBUS_A, IBUS_DI, IBUS_DO;
   logic        IBUS_WE, IBUS_REQ, IBUS_ACT;
   logic [26:0] A;
   logic [31:0] DO, DI;
   logic [3:0]  CS_N, WE_N;
   logic        RD_N, WAIT_N;

   always #5 CLK = ~CLK;

   sh7604_bsc dut (
      .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
      .DBUS_A(DBUS_A), .DBUS_DI(DBUS_DI), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA),
      .DBUS_WE(DBUS_WE), .DBUS_REQ(DBUS_REQ), .DBUS_BURST(DBUS_BURST), .DBUS_LOCK(DBUS_LOCK),
      .DBUS_WAIT(DBUS_WAIT), .BSC_ACK(BSC_ACK),
      .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_WE(IBUS_WE),
      .IBUS_REQ(IBUS_REQ), .IBUS_ACT(IBUS_ACT),
      .A(A), .DO(DO), .DI(DI), .CS_N(CS_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N)
   );

   typedef struct {
      logic        ce, req, we, burst;
      logic [31:0] addr, wdata;
      logic [3:0]  ba;
      logic [31:0] di;
      logic        wn, iw;
      logic [15:0] idi;
      logic        e_ack;
      logic [3:0]  e_cs;
      logic        e_rd;
      logic [3:0]  e_we;
      logic        e_dw;
      logic [26:0] e_a;
      logic [31:0] e_ddo, e_do, e_ibo;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic ce, req, we, burst, input logic [31:0] addr, wdata,
                      input logic [3:0] ba, input logic [31:0] di, input logic wn, iw,
                      input logic [15:0] idi, input logic e_ack, input logic [3:0] e_cs,
                      input logic e_rd, input logic [3:0] e_we, input logic e_dw,
                      input logic [26:0] e_a, input logic [31:0] e_ddo, e_do, e_ibo);
      vec_t v;
      v.ce = ce; v.req = req; v.we = we; v.burst = burst; v.addr = addr; v.wdata = wdata;
      v.ba = ba; v.di = di; v.wn = wn; v.iw = iw; v.idi = idi;
      v.e_ack = e_ack; v.e_cs = e_cs; v.e_rd = e_rd; v.e_we = e_we; v.e_dw = e_dw;
      v.e_a = e_a; v.e_ddo = e_ddo; v.e_do = e_do; v.e_ibo = e_ibo;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ce, req, we, burst, lock, input logic [31:0] addr, wdata,
                        input logic [3:0] ba, input logic [31:0] di, input logic wn, iw,
                        input logic [15:0] idi);
      @(negedge CLK);
      CE_R = ce; DBUS_REQ = req; DBUS_WE = we; DBUS_BURST = burst; DBUS_LOCK = lock;
      DBUS_A = addr; DBUS_DI = wdata; DBUS_BA = ba; DI = di; WAIT_N = wn;
      IBUS_REQ = iw; IBUS_WE = iw; IBUS_DI = {16'h0, idi};
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int cnt, ph, gap;
      logic [26:0] last_a;

      RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1;
      DBUS_A = '0; DBUS_DI = '0; DBUS_BA = '0; DBUS_WE = 0; DBUS_REQ = 0;
      DBUS_BURST = 0; DBUS_LOCK = 0; DI = '0; WAIT_N = 1;
      IBUS_A = WCR_A; IBUS_DI = '0; IBUS_WE = 0; IBUS_REQ = 0;

      // WCR=0, area-1 read, with one CE_R-gated cycle held in T1
      add(1,0,0,0, 32'h0,32'h0,4'h0,32'h0,1,1,16'h0000, 0,4'hF,1,4'hF,0,27'h0,32'h0,32'h0,32'h0000AAFF);
      add(1,1,0,0, 32'h02000000,0,4'hF,32'h12345678,1,0,0, 1,4'hD,0,4'hF,1,27'h2000000,0,0,0);
      add(0,1,0,0, 32'h02000000,0,4'hF,32'h12345678,1,0,0, 1,4'hD,0,4'hF,1,27'h2000000,0,0,0);
      add(1,1,0,0, 32'h02000000,0,4'hF,32'h12345678,1,0,0, 1,4'hD,0,4'hF,0,27'h2000000,32'h12345678,0,0);
      add(1,0,0,0, 0,0,4'h0,0,1,0,0, 0,4'hF,1,4'hF,0,27'h2000000,32'h12345678,0,0);
      // area 0 W=3 write, BA=1100
      add(1,0,0,0, 0,0,4'h0,0,1,1,16'h0003, 0,4'hF,1,4'hF,0,27'h2000000,32'h12345678,0,0);
      add(1,1,1,0, 32'h40,32'hCAFEF00D,4'hC,0,1,0,0, 1,4'hE,1,4'hF,1,27'h40,32'h12345678,32'hCAFEF00D,3);
      for (int k = 0; k < 3; k++)
         add(1,1,1,0, 32'h40,32'hCAFEF00D,4'hC,0,1,0,0, 1,4'hE,1,4'h3,1,27'h40,32'h12345678,32'hCAFEF00D,3);
      add(1,1,1,0, 32'h40,32'hCAFEF00D,4'hC,0,1,0,0, 1,4'hE,1,4'h3,0,27'h40,32'h0,32'hCAFEF00D,3);
      add(1,0,0,0, 0,0,4'h0,0,1,0,0, 0,4'hF,1,4'hF,0,27'h40,32'h0,32'hCAFEF00D,3);
      // area 1 W=1 read with WAIT_N low for 3 extra periods
      add(1,0,0,0, 0,0,4'h0,0,1,1,16'h0004, 0,4'hF,1,4'hF,0,27'h40,32'h0,32'hCAFEF00D,3);
      for (int k = 0; k < 5; k++)
         add(1,1,0,0, 32'h02000100,0,4'hF,32'hDEADBEEF,0,0,0, 1,4'hD,0,4'hF,1,27'h2000100,0,0,4);
      add(1,1,0,0, 32'h02000100,0,4'hF,32'h55AA55AA,1,0,0, 1,4'hD,0,4'hF,0,27'h2000100,32'h55AA55AA,0,4);
      add(1,0,0,0, 0,0,4'h0,0,1,0,0, 0,4'hF,1,4'hF,0,27'h2000100,32'h55AA55AA,0,4);
      // W=0 burst from 0x10
      add(1,0,0,0, 0,0,4'h0,0,1,1,16'h0000, 0,4'hF,1,4'hF,0,27'h2000100,32'h55AA55AA,0,4);
      add(1,1,0,1, 32'h10,0,4'hF,32'h11111111,1,0,0, 1,4'hE,0,4'hF,1,27'h10,32'h55AA55AA,0,0);
      add(1,1,0,1, 32'h10,0,4'hF,32'h11111111,1,0,0, 1,4'hE,0,4'hF,0,27'h10,32'h11111111,0,0);
      add(1,1,0,1, 32'h10,0,4'hF,32'h22222222,1,0,0, 1,4'hE,0,4'hF,0,27'h14,32'h22222222,0,0);
      add(1,1,0,1, 32'h10,0,4'hF,32'h33333333,1,0,0, 1,4'hE,0,4'hF,0,27'h18,32'h33333333,0,0);
      add(1,1,0,1, 32'h10,0,4'hF,32'h44444444,1,0,0, 1,4'hE,0,4'hF,0,27'h1C,32'h44444444,0,0);
      add(1,0,0,0, 0,0,4'h0,0,1,0,0, 0,4'hF,1,4'hF,0,27'h1C,32'h44444444,0,0);

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_cs_n", {28'h0, CS_N}, 32'hF);
      chk("rst_rd_n", {31'h0, RD_N}, 32'h1);
      chk("rst_we_n", {28'h0, WE_N}, 32'hF);
      chk("rst_ack", {31'h0, BSC_ACK}, 32'h0);
      chk("rst_a", {5'h0, A}, 32'h0);
      chk("rst_do", DO, 32'h0);
      chk("rst_dbus_do", DBUS_DO, 32'h0);
      chk("rst_ibus_do", IBUS_DO, 32'h0);
      chk("ibus_act_hit", {31'h0, IBUS_ACT}, 32'h1);
      IBUS_A = 32'hFFFFFFEC;
      #1 chk("ibus_act_miss", {31'h0, IBUS_ACT}, 32'h0);
      IBUS_A = WCR_A;
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         v = tbl[i];
         drive(v.ce, v.req, v.we, v.burst, 1'b0, v.addr, v.wdata, v.ba, v.di, v.wn, v.iw, v.idi);
         chk($sformatf("v%0d_ack", i), {31'h0, BSC_ACK}, {31'h0, v.e_ack});
         chk($sformatf("v%0d_cs_n", i), {28'h0, CS_N}, {28'h0, v.e_cs});
         chk($sformatf("v%0d_rd_n", i), {31'h0, RD_N}, {31'h0, v.e_rd});
         chk($sformatf("v%0d_we_n", i), {28'h0, WE_N}, {28'h0, v.e_we});
         chk($sformatf("v%0d_dbus_wait", i), {31'h0, DBUS_WAIT}, {31'h0, v.e_dw});
         chk($sformatf("v%0d_a", i), {5'h0, A}, {5'h0, v.e_a});
         chk($sformatf("v%0d_dbus_do", i), DBUS_DO, v.e_ddo);
         chk($sformatf("v%0d_do", i), DO, v.e_do);
         chk($sformatf("v%0d_ibus_do", i), IBUS_DO, v.e_ibo);
      end

      // reset in TW of the second beat of a W=2 burst
      drive(1,0,0,0,0, 0,0,4'h0,0,1,1,16'h0002);
      drive(1,1,0,1,0, 32'h100,0,4'hF,0,1,0,0);
      repeat (4) drive(1,0,0,0,0, 0,0,4'h0,0,1,0,0);
      chk("burst2_a", {5'h0, A}, 32'h104);
      chk("burst2_cs_n", {28'h0, CS_N}, 32'hE);
      chk("burst2_ack", {31'h0, BSC_ACK}, 32'h1);
      #2 RST = 1'b1;
      #1;
      chk("arst_cs_n", {28'h0, CS_N}, 32'hF);
      chk("arst_rd_n", {31'h0, RD_N}, 32'h1);
      chk("arst_we_n", {28'h0, WE_N}, 32'hF);
      chk("arst_ack", {31'h0, BSC_ACK}, 32'h0);
      chk("arst_a", {5'h0, A}, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      drive(1,0,0,0,0, 0,0,4'h0,0,1,0,0);
      chk("arst_wcr", IBUS_DO, 32'h0000AAFF);
      drive(1,0,0,0,0, 0,0,4'h0,0,1,1,16'h0000);
      drive(1,1,0,1,0, 32'h20,0,4'hF,32'h0,1,0,0);
      cnt = BSC_ACK ? 1 : 0;
      last_a = A;
      for (int c = 0; c < 12; c++) begin
         drive(1,0,0,0,0, 0,0,4'h0,0,1,0,0);
         if (BSC_ACK) begin
            cnt++;
            last_a = A;
         end
      end
      chk("post_rst_burst_len", cnt, 32'd5);
      chk("post_rst_burst_last_a", {5'h0, last_a}, 32'h2C);

      // back-to-back reads with LOCK low then high
      for (int l = 0; l < 2; l++) begin
         ph = 0;
         gap = 0;
         repeat (2) drive(1,0,0,0,0, 0,0,4'h0,0,1,0,0);
         for (int c = 0; c < 12 && ph < 3; c++) begin
            drive(1,1,0,0,l[0], 32'h300,0,4'hF,32'h0,1,0,0);
            case (ph)
               0: if (BSC_ACK) ph = 1;
               1: if (!BSC_ACK) begin ph = 2; gap = 1; end
               default: if (BSC_ACK) ph = 3; else gap++;
            endcase
         end
         chk($sformatf("b2b_lock%0d_started", l), ph, 32'd3);
         chk($sformatf("b2b_lock%0d_gap", l), gap, (l == 0) ? IDLE_GAP : 1);
         repeat (3) drive(1,0,0,0,0, 0,0,4'h0,0,1,0,0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
